// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkgate_pkg.sv
// Shared definitions for the idle-driven integrated clock gate.
//   state_t : controller FSM states (RUN, COUNT, GATED, WAKE)
//   GE_W    : width of the GATE_EVENTS counter
//   GE_MAX  : saturation value of the GATE_EVENTS counter
package gf180mcu_fd_sc_mcu7t5v0__clkgate_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_COUNT = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  localparam int unsigned GE_W = 8;
  localparam logic [GE_W-1:0] GE_MAX = '1;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__icg_latch.sv
// Latch-based clock gate cell.
//   CLK : source clock
//   E   : functional enable, captured while CLK is low
//   TE  : scan test enable, ORed into the captured enable
//   Q   : gated clock, CLK AND latched enable
// The latch is transparent only while CLK is low, so an enable change
// arriving during the high phase can never shorten or split a pulse.
module gf180mcu_fd_sc_mcu7t5v0__icg_latch (
  input  logic CLK,
  input  logic E,
  input  logic TE,
  output logic Q
);

  logic en_latched;

  always_latch begin
    if (!CLK) begin
      en_latched <= E | TE;
    end
  end

  assign Q = CLK & en_latched;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__icgtp_idle_ctrl.sv
// Idle-detecting clock gate controller.
//   CLK, RST     : free-running clock, synchronous active-high reset
//   BUSY         : downstream activity (high = not idle)
//   WAKE_REQ     : explicit request to restore the clock
//   FORCE_ON     : keeps the clock running, blocks gating
//   TE           : scan test enable, forces the gate open
//   GCLK         : gated clock output
//   GATED        : high while the controller holds the clock off
//   WAKE_ACK     : one-cycle pulse while leaving the gated state
//   GATE_EVENTS  : saturating count of entries into the gated state
//   VDD, VSS     : supply pins, no functional use
// After IDLE_CYCLES consecutive idle edges the clock is gated; the first
// non-idle edge moves through WAKE (one cycle) back to RUN.
module gf180mcu_fd_sc_mcu7t5v0__icgtp_idle_ctrl
  import gf180mcu_fd_sc_mcu7t5v0__clkgate_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            BUSY,
  input  logic            WAKE_REQ,
  input  logic            FORCE_ON,
  input  logic            TE,
  output logic            GCLK,
  output logic            GATED,
  output logic            WAKE_ACK,
  output logic [GE_W-1:0] GATE_EVENTS,
  inout  wire             VDD,
  inout  wire             VSS
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [GE_W-1:0]   gate_events, gate_events_n;
  logic              idle;
  logic              en;
  logic              supply_unused;

  assign supply_unused = VDD ^ VSS;

  assign idle = !BUSY && !WAKE_REQ && !FORCE_ON;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_RUN;
      cnt         <= '0;
      gate_events <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      gate_events <= gate_events_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    gate_events_n = gate_events;
    case (state)
      ST_RUN: begin
        if (idle) begin
          state_n = ST_COUNT;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_COUNT: begin
        // A non-idle input (including FORCE_ON) always wins over expiry.
        if (!idle) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(IDLE_CYCLES - 1)) begin
          state_n = ST_GATED;
          cnt_n   = '0;
          if (gate_events != GE_MAX) begin
            gate_events_n = gate_events + 8'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_GATED: begin
        if (!idle) begin
          state_n = ST_WAKE;
        end
      end
      ST_WAKE: begin
        state_n = ST_RUN;
        cnt_n   = '0;
      end
      default: begin
        state_n = ST_RUN;
        cnt_n   = '0;
      end
    endcase
  end

  assign GATED       = (state == ST_GATED);
  assign WAKE_ACK    = (state == ST_WAKE);
  assign GATE_EVENTS = gate_events;

  // Reset forces the gate open so downstream synchronous resets see edges.
  assign en = (state != ST_GATED) || RST;

  gf180mcu_fd_sc_mcu7t5v0__icg_latch u_icg (
    .CLK (CLK),
    .E   (en),
    .TE  (TE),
    .Q   (GCLK)
  );

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__icgtp_idle_ctrl.md
GF180MCU_FD_SC_MCU7T5V0__ICGTP_IDLE_CTRL -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__icgtp_idle_ctrl

Interface
REQ-001 SHALL have one clock, CLK; reset is synchronous and active-high, RST.
REQ-002 SHALL have parameter IDLE_CYCLES, default 8: consecutive idle CLK edges before gating; legal range 2..15.
REQ-003 SHALL have parameter CNT_W, default 4: idle counter width.
REQ-004 SHALL have port CLK, input, 1 bit: free-running source clock.
REQ-005 SHALL have port RST, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port BUSY, input, 1 bit: downstream activity; high = not idle.
REQ-007 SHALL have port WAKE_REQ, input, 1 bit: explicit request to restore the clock.
REQ-008 SHALL have port FORCE_ON, input, 1 bit: holds the clock running; blocks gating.
REQ-009 SHALL have port TE, input, 1 bit: scan test enable; forces the latch enable high, FSM unaffected.
REQ-010 SHALL have port GCLK, output, 1 bit: gated clock = CLK AND latched enable.
REQ-011 SHALL have port GATED, output, 1 bit: high while the FSM is in GATED.
REQ-012 SHALL have port WAKE_ACK, output, 1 bit: one-cycle pulse in WAKE.
REQ-013 SHALL have port GATE_EVENTS, output, 8 bits: saturating count of entries into GATED.
REQ-014 SHALL have ports VDD and VSS, inout, 1 bit each: supply pins, functionally unused.

Function
REQ-015 SHALL define "idle" as BUSY=0, WAKE_REQ=0 and FORCE_ON=0, sampled on CLK rising edge.
REQ-016 SHALL implement FSM states RUN, COUNT, GATED and WAKE, clocked by ungated CLK.
REQ-017 RUN: on idle, SHALL go to COUNT with cnt=1; otherwise SHALL stay in RUN.
REQ-018 COUNT: non-idle SHALL go to RUN with cnt=0; idle with cnt==IDLE_CYCLES-1 SHALL go to GATED; otherwise cnt SHALL increment.
REQ-019 GATED: non-idle SHALL go to WAKE; otherwise SHALL stay in GATED.
REQ-020 WAKE: SHALL go unconditionally to RUN on the next edge with cnt=0.
REQ-021 Internal enable EN SHALL be (state!=GATED) OR TE.
REQ-022 Latch SHALL be transparent while CLK=0 and hold while CLK=1; GCLK SHALL be CLK AND latch output, so enable changes never truncate a high phase.
REQ-023 Latency: after IDLE_CYCLES consecutive idle edges, GATED=1 and the next CLK high pulse SHALL be absent on GCLK.
REQ-024 Latency: the first non-idle edge in GATED enters WAKE; GCLK SHALL pulse on the following rising edge.
REQ-025 WAKE_ACK SHALL be high for exactly the one cycle spent in WAKE.
REQ-026 GATE_EVENTS SHALL increment on each COUNT->GATED transition and saturate at 255.
REQ-027 Simultaneous idle-expiry and FORCE_ON: FORCE_ON SHALL win, giving a transition to RUN.
REQ-028 TE=1 in GATED SHALL run GCLK while GATED remains 1.

Reset
REQ-029 While RST=1 at an edge: state SHALL be RUN; cnt, GATED, WAKE_ACK and GATE_EVENTS SHALL be 0.
REQ-030 EN SHALL be 1 during reset, so GCLK runs and downstream synchronous resets take effect.
REQ-031 RST asserted mid-COUNT or in GATED SHALL return the FSM to RUN on that edge with no WAKE_ACK pulse.

Structure
REQ-032 Package gf180mcu_fd_sc_mcu7t5v0__clkgate_pkg SHALL hold the state enum and the GATE_EVENTS width/saturation constant.
REQ-033 Latch plus AND SHALL be the sub-module gf180mcu_fd_sc_mcu7t5v0__icg_latch (CLK, E, TE, Q).

Verification (IDLE_CYCLES=4)
REQ-034 Bench SHALL cover: BUSY low for 4 edges -> GATED=1 after 4th edge; next GCLK pulse missing; GATE_EVENTS=1.
REQ-035 Bench SHALL cover: BUSY low 3 edges, high on 4th -> state RUN, cnt=0, GATED never 1.
REQ-036 Bench SHALL cover: in GATED, WAKE_REQ=1 for one edge -> WAKE_ACK=1 one cycle; GCLK resumes next edge; GATED=0.
REQ-037 Bench SHALL cover: FORCE_ON=1 on the expiring 4th idle edge -> RUN, GATE_EVENTS unchanged.
REQ-038 Bench SHALL cover: 300 gate/wake cycles -> GATE_EVENTS=255; RST in GATED -> RUN, all outputs 0, GCLK running.
REQ-039 Bench SHALL cover: TE=1 in GATED -> GCLK toggles, GATED=1; glitch check: no GCLK high pulse narrower than CLK high.
